// File: rtl/adder_feed_pkg.sv
// Shared types and constants for the adder operand feeder.
// Optional statistics counter is enabled with ADDER_FEED_STATS_EN.
package adder_feed_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int STAT_W     = 16;

  typedef enum logic [0:0] {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } feed_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
  } pair_t;

endpackage

// File: rtl/adder_feed_if.sv
// Operand stream in, issued pair out; the feeder connects through the slave modport.
interface adder_feed_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              issue_en;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              valid;

  modport master (output in_valid, in_data, issue_en, input in_ready, a, b, valid);
  modport slave  (input in_valid, in_data, issue_en, output in_ready, a, b, valid);
endinterface

// File: rtl/adder_feed_fifo.sv
// Synchronous FIFO of operand pairs; head entry is always visible on rdata_o.
module adder_feed_fifo
  import adder_feed_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = pair_t,
  parameter int  LVL_W   = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  ENTRY_T           wdata_i,
  input  logic             pop_i,
  output ENTRY_T           rdata_o,
  output logic [LVL_W-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);

  ENTRY_T           mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LVL_W-1:0] level_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: level/pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_i && !reset && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/adder_operand_feeder.sv
// Pairs a serial operand stream into (a, b), buffers pairs and issues them to the adder.
// ADDER_FEED_STATS_EN adds a 16-bit pair_count output of issued pairs.
module adder_operand_feeder
  import adder_feed_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  adder_feed_if.slave      bus,
`ifdef ADDER_FEED_STATS_EN
  output logic [STAT_W-1:0] pair_count,
`endif
  output logic [LVL_W-1:0] level
);
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } feed_pair_t;

  feed_state_e       state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              valid_q, valid_d;
  logic [LVL_W-1:0]  fifo_level;
  feed_pair_t        head, wpair;
  logic              in_ready, accept, push, pop;

  // Registered terms only, so issue_en never reaches in_ready combinationally.
  assign in_ready = (state_q == WAIT_A) || (fifo_level != LVL_W'(DEPTH));
  assign accept   = bus.in_valid && in_ready && !flush;
  assign push     = accept && (state_q == WAIT_B);
  assign pop      = (fifo_level != '0) && bus.issue_en && !flush;
  assign wpair    = '{a: hold_q, b: bus.in_data};

  adder_feed_fifo #(.DEPTH(DEPTH), .ENTRY_T(feed_pair_t), .LVL_W(LVL_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (wpair),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = pop;
    if (flush) begin
      state_d = WAIT_A;
      hold_d  = '0;
    end else if (accept) begin
      if (state_q == WAIT_A) begin
        hold_d  = bus.in_data;
        state_d = WAIT_B;
      end else begin
        state_d = WAIT_A;
      end
    end
    if (pop) begin
      a_d = head.a;
      b_d = head.b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_A;
      hold_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

`ifdef ADDER_FEED_STATS_EN
  logic [STAT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset || flush) cnt_q <= '0;
    else if (pop)       cnt_q <= cnt_q + STAT_W'(1);
  end
  assign pair_count = cnt_q;
`endif

  assign bus.in_ready = in_ready;
  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.valid    = valid_q;
  assign level        = fifo_level;

endmodule

// File: tb/tb_adder_operand_feeder.sv
// Directed bench for adder_operand_feeder (DATA_W=4, DEPTH=4).
module tb_adder_operand_feeder;
  logic       clk = 1'b0;
  logic       reset, flush;
  logic [2:0] level;
  int         checks = 0;
  int         errors = 0;
`ifdef ADDER_FEED_STATS_EN
  logic [15:0] pair_count;
`endif

  adder_feed_if #(.DATA_W(4)) bus ();

  adder_operand_feeder #(.DATA_W(4), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus.slave),
`ifdef ADDER_FEED_STATS_EN
    .pair_count (pair_count),
`endif
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] ea, input logic [3:0] eb);
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
    chk({tag, ".a"}, 32'(bus.a), 32'(ea));
    chk({tag, ".b"}, 32'(bus.b), 32'(eb));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.issue_en = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 4'd0, 4'd0);
    chk("reset.level", 32'(level), 0);
    chk("reset.in_ready", 32'(bus.in_ready), 1);
    reset = 1'b0;

    // Single pair 3,5 with issue enabled: pulse two edges after 5 is taken.
    bus.issue_en = 1'b1; bus.in_valid = 1'b1; bus.in_data = 4'd3;
    tick();
    bus.in_data = 4'd5;
    tick();
    chk("p1.level_k", 32'(level), 1);
    chk("p1.valid_k", 32'(bus.valid), 0);
    bus.in_valid = 1'b0;
    tick();
    chk_out("p1.issue", 1'b1, 4'd3, 4'd5);
    chk("p1.level_k1", 32'(level), 0);
    tick();
    chk("p1.valid_drop", 32'(bus.valid), 0);

    // Fill with issue disabled: operands 1..10, 9th held, 10th stalls.
    bus.issue_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 4'(i);
      tick();
      if (i == 8) begin
        chk("fill.level8", 32'(level), 4);
        chk("fill.ready8", 32'(bus.in_ready), 1);
      end
      if (i == 9) chk("fill.ready9", 32'(bus.in_ready), 0);
    end
    chk("fill.level10", 32'(level), 4);
    chk("fill.ready10", 32'(bus.in_ready), 0);
    chk("fill.novalid", 32'(bus.valid), 0);

    // Drain: 10 is still offered and gets taken right after the first pop.
    bus.issue_en = 1'b1;
    tick();
    chk_out("drain0", 1'b1, 4'd1, 4'd2);
    chk("drain0.level", 32'(level), 3);
    chk("drain0.ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    chk_out("drain1", 1'b1, 4'd3, 4'd4);
    chk("drain1.level", 32'(level), 3);
    tick();
    chk_out("drain2", 1'b1, 4'd5, 4'd6);
    tick();
    chk_out("drain3", 1'b1, 4'd7, 4'd8);
    tick();
    chk_out("drain4", 1'b1, 4'd9, 4'd10);
    chk("drain4.level", 32'(level), 0);
    tick();
    chk_out("drain.idle", 1'b0, 4'd9, 4'd10);

    // Flush discards held 7; flush-cycle operand 9 is not consumed.
    bus.in_valid = 1'b1; bus.in_data = 4'd7;
    tick();
    flush = 1'b1; bus.in_data = 4'd9;
    tick();
    flush = 1'b0;
    chk("flush.valid", 32'(bus.valid), 0);
    chk("flush.level", 32'(level), 0);
    bus.in_data = 4'd1;
    tick();
    bus.in_data = 4'd2;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk_out("flush.pair", 1'b1, 4'd1, 4'd2);
    tick();
    chk("flush.single", 32'(bus.valid), 0);
`ifdef ADDER_FEED_STATS_EN
    chk("stats.after_flush", 32'(pair_count), 1);
`endif

    // Reset mid-burst with level=2 and a held operand.
    bus.issue_en = 1'b0;
    for (int i = 11; i <= 15; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 4'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mid.level", 32'(level), 2);
    reset = 1'b1; bus.issue_en = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("mid.reset", 1'b0, 4'd0, 4'd0);
    chk("mid.level0", 32'(level), 0);
    chk("mid.ready", 32'(bus.in_ready), 1);
`ifdef ADDER_FEED_STATS_EN
    chk("stats.reset", 32'(pair_count), 0);
`endif
    tick();
    chk("mid.nopulse", 32'(bus.valid), 0);
    // Held 15 must be gone: next pair is (6,4), not (15,6).
    bus.in_valid = 1'b1; bus.in_data = 4'd6;
    tick();
    bus.in_data = 4'd4;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk_out("mid.pair", 1'b1, 4'd6, 4'd4);
`ifdef ADDER_FEED_STATS_EN
    chk("stats.one", 32'(pair_count), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_operand_feeder.md
# adder_operand_feeder

Upstream stage of the adder. It accepts a serial stream of single operands over a valid/ready handshake and pairs consecutive operands into (a, b). Pairs are buffered in a small FIFO and issued to the adder's `a`, `b` and `valid` inputs one pair per cycle while the downstream stage permits it. The adder itself has no back-pressure, so this block absorbs bursts and provides flow control.

## Interface
Parameters:
- `DATA_W`, default 4: operand width; matches the adder's `a`/`b` width.
- `DEPTH`, default 4: FIFO depth in pairs; must be a power of 2 and ≥ 2.

Ports:
- Clocking: one clock (`clk`). Reset `reset` is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of all buffered state.
- `in_valid`  in  1  operand present.
- `in_data`  in  DATA_W  operand value.
- `in_ready`  out  1  operand accepted when `in_valid && in_ready` at a rising edge.
- `issue_en`  in  1  downstream permits issue this cycle.
- `a`  out  DATA_W  first operand of the issued pair (to adder `a`).
- `b`  out  DATA_W  second operand of the issued pair (to adder `b`).
- `valid`  out  1  one-cycle pulse per issued pair (to adder `valid`).
- `level`  out  $clog2(DEPTH+1)  number of pairs buffered.
- `pair_count`  out  16  present only with `ADDER_FEED_STATS_EN`.

## Operation
- Pairing FSM has two states, WAIT_A and WAIT_B.
  - WAIT_A: an accepted operand is stored in the hold register; next state WAIT_B.
  - WAIT_B: an accepted operand is combined with the hold register as (a=hold, b=in_data) and written to the FIFO; next state WAIT_A.
- `in_ready` = (state==WAIT_A) || (level != DEPTH).
  - Registered terms only; no combinational path from `issue_en`.
  - Consequence: in WAIT_B with the FIFO full, `in_ready` stays low even in a cycle where a pair is being issued.
- Issue: when `level != 0 && issue_en`, pop the head pair into the `a`/`b` output registers and set `valid`=1 for the next cycle.
  - Otherwise `valid`=0 and `a`/`b` hold their last values.
- Simultaneous write and pop: `level` is unchanged and both actions occur.
- Pointers are log2(DEPTH) bits and wrap naturally. `level` ranges 0..DEPTH.
- `flush` (priority over input and issue): FIFO emptied, state returns to WAIT_A, the held first operand is discarded, and `valid`=0 on the next cycle. The handshake in the flush cycle is ignored, so no operand is consumed.
- Reset values:
  - state=WAIT_A, `level`=0, `a`=0, `b`=0, `valid`=0, `pair_count`=0.
  - `in_ready`=1 immediately after reset.
- A reset in mid-burst discards the hold register and all buffered pairs.

## Timing
- Second operand accepted at edge k → pair visible in `level` after edge k → if `issue_en` is high in that cycle, `valid` is high in the cycle after edge k+1. Minimum latency is 2 cycles from accept to `valid`.
- Sustained throughput is 1 pair per 2 input cycles and 1 issue per cycle.
- `valid` is never high for more than one cycle per pair. Back-to-back pairs produce back-to-back pulses.
- `level` updates at the same edge as the push or pop.

## Configuration
- Macro: `ADDER_FEED_STATS_EN`.
- Defined: the 16-bit `pair_count` port exists.
  - Increments at every edge that loads an issued pair.
  - Wraps 0xFFFF→0x0000.
  - Cleared by `reset` and by `flush`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `adder_feed_pkg` holds:
  - the state enum typedef (WAIT_A, WAIT_B);
  - the pair struct typedef {a, b};
  - `DATA_W_DEF`=4 and `STAT_W`=16.
- Sub-module `adder_feed_fifo`: synchronous FIFO of pair structs with push, pop and level. This module instantiates it and contains the FSM, hold register and output registers.

## Test plan
- Reset, then feed 3, 5 with `issue_en`=1 → `valid` pulses once with a=3, b=5, exactly 2 cycles after 5 is accepted; `level` returns to 0.
- Hold `issue_en`=0 and stream 10 operands with DEPTH=4 → `level`=4 after 8 operands; `in_ready` low in WAIT_B; the 9th operand is accepted and held; the 10th stalls.
- From the full state, raise `issue_en` → 4 consecutive `valid` pulses in FIFO order; `in_ready` rises one cycle after the first pop.
- Feed 7, assert `flush`, then feed 1, 2 → the single pulse has a=1, b=2 (7 discarded).
- Assert `reset` with `level`=2 and state WAIT_B → all outputs at reset values next cycle; no pulse follows.
- With `ADDER_FEED_STATS_EN` and `pair_count` preloaded near wrap (issue 65537 pairs) → `pair_count` reads 1.
